// File: rtl/logger_line_arbiter.sv
// logger_line_arbiter: round-robin, line-atomic arbiter for a shared byte-wide logger FIFO write port
module logger_line_arbiter #(
  parameter int N_REQ      = 2,
  parameter int LINE_BYTES = 57,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   s_valid,
  input  logic [8*N_REQ-1:0] s_data,
  input  logic [N_REQ-1:0]   s_last,
  output logic [N_REQ-1:0]   s_ready,
  output logic               fifo_wr_en,
  output logic [7:0]         fifo_din,
  input  logic               fifo_full,
  input  logic               fifo_prog_full,
  input  logic               fifo_wr_rst_busy,
  output logic               busy,
  output logic [CNT_W-1:0]   line_cnt,
  output logic [CNT_W-1:0]   trunc_cnt
);
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  localparam int BW = $clog2(LINE_BYTES + 1);
  typedef enum logic [1:0] {IDLE, STREAM, TRUNC, DRAIN} state_t;
  state_t           state_q, state_d;
  logic [IW-1:0]    grant_q, grant_d, rr_ptr_q, rr_ptr_d, pick, grant_nxt;
  logic [BW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d, trunc_cnt_q, trunc_cnt_d;
  logic             wr_ok, g_valid, g_last, cut, done;
  assign wr_ok     = !fifo_full && !fifo_wr_rst_busy;
  assign g_valid   = s_valid[grant_q];
  assign g_last    = s_last[grant_q];
  assign cut       = state_q == STREAM && byte_cnt_q == BW'(LINE_BYTES - 1) && g_valid && !g_last;
  assign grant_nxt = IW'((int'(grant_q) + 1) % N_REQ);
  assign done      = (state_q == STREAM && fifo_wr_en && g_last) || (state_q == DRAIN && g_valid && g_last);
  assign busy      = state_q != IDLE;
  assign line_cnt  = line_cnt_q;
  assign trunc_cnt = trunc_cnt_q;
  always_comb begin
    pick = rr_ptr_q;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (s_valid[(int'(rr_ptr_q) + i) % N_REQ]) pick = IW'((int'(rr_ptr_q) + i) % N_REQ);
  end
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = done ? grant_nxt : rr_ptr_q;
    byte_cnt_d  = byte_cnt_q + BW'(state_q == STREAM && fifo_wr_en);
    line_cnt_d  = line_cnt_q + CNT_W'(done && line_cnt_q != '1);
    trunc_cnt_d = trunc_cnt_q + CNT_W'(state_q == TRUNC && wr_ok && trunc_cnt_q != '1);
    case (state_q)
      IDLE: if (|s_valid && !fifo_prog_full && !fifo_wr_rst_busy) begin
        state_d    = STREAM;
        grant_d    = pick;
        byte_cnt_d = '0;
      end
      STREAM:  state_d = done ? IDLE : cut ? TRUNC : STREAM;
      TRUNC:   state_d = wr_ok ? DRAIN : TRUNC;
      default: state_d = done ? IDLE : DRAIN;
    endcase
  end
  always_comb begin
    s_ready          = '0;
    s_ready[grant_q] = state_q == DRAIN || (state_q == STREAM && wr_ok && !cut);
    fifo_wr_en       = state_q == TRUNC ? wr_ok : state_q == STREAM && g_valid && wr_ok && !cut;
    fifo_din         = state_q == TRUNC ? 8'h0A : state_q == STREAM ? s_data[{grant_q, 3'b000} +: 8] : 8'h00;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      byte_cnt_q  <= '0;
      line_cnt_q  <= '0;
      trunc_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      line_cnt_q  <= line_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
    end
endmodule
